// File: rtl/afe_config_sequencer.sv
// ----------------------------------------------------------------------------
// afe_config_sequencer
//
// Walks a registered command ROM from address 0 and ships every 24-bit word
// to an analog front end over a mode-0 SPI link (MSB first). A pass ends at
// the first END_CODE word (never transmitted) or after address 255.
//
// Ports
//   clk          in   sole clock, rising edge
//   reset_n      in   synchronous active-low reset
//   start        in   one-cycle pulse, accepted only while idle
//   rom_address  out  [7:0]  command ROM word address
//   rom_command  in   [23:0] ROM data, valid one clk after rom_address
//   spi_cs_n     out  chip select, active low
//   spi_sclk     out  serial clock, idles low
//   spi_mosi     out  serial data, MSB first
//   busy         out  high for the duration of a pass
//   done         out  sticky pass-complete flag, cleared by the next start
//   cmd_count    out  [8:0]  commands fully transmitted this / last pass
// ----------------------------------------------------------------------------
module afe_config_sequencer #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned GAP_CYCLES = 8,
    parameter logic [23:0] END_CODE   = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic [7:0]  rom_address,
    input  logic [23:0] rom_command,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    output logic        busy,
    output logic        done,
    output logic [8:0]  cmd_count
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLatch,
        StShift,
        StGap,
        StFinish
    } state_e;

    // FETCH and LATCH already keep cs_n high for two cycles, so the GAP state
    // dwells for the remainder; the chip-select high time between frames is
    // then exactly GAP_CYCLES (floor of 3 because of the ROM latency).
    localparam int unsigned GapDwell = (GAP_CYCLES > 2) ? GAP_CYCLES - 2 : 1;
    localparam logic [7:0]  DivLast  = 8'(CLK_DIV - 1);
    localparam logic [7:0]  GapLast  = 8'(GapDwell - 1);

    state_e      r_state, w_state;
    logic [7:0]  r_addr,  w_addr;
    logic [23:0] r_shift, w_shift;
    logic [7:0]  r_div,   w_div;
    logic [4:0]  r_bit,   w_bit;
    logic [7:0]  r_gap,   w_gap;
    logic        r_cs_n,  w_cs_n;
    logic        r_sclk,  w_sclk;
    logic        r_busy,  w_busy;
    logic        r_done,  w_done;
    logic [8:0]  r_cnt,   w_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= StIdle;
            r_addr  <= 8'd0;
            r_shift <= 24'd0;
            r_div   <= 8'd0;
            r_bit   <= 5'd0;
            r_gap   <= 8'd0;
            r_cs_n  <= 1'b1;
            r_sclk  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= 9'd0;
        end else begin
            r_state <= w_state;
            r_addr  <= w_addr;
            r_shift <= w_shift;
            r_div   <= w_div;
            r_bit   <= w_bit;
            r_gap   <= w_gap;
            r_cs_n  <= w_cs_n;
            r_sclk  <= w_sclk;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_cnt   <= w_cnt;
        end
    end

    always_comb begin
        w_state = r_state;
        w_addr  = r_addr;
        w_shift = r_shift;
        w_div   = r_div;
        w_bit   = r_bit;
        w_gap   = r_gap;
        w_cs_n  = r_cs_n;
        w_sclk  = r_sclk;
        w_busy  = r_busy;
        w_done  = r_done;
        w_cnt   = r_cnt;

        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_addr  = 8'd0;
                    w_done  = 1'b0;
                    w_cnt   = 9'd0;
                    w_busy  = 1'b1;
                    w_state = StFetch;
                end
            end

            StFetch: begin
                w_state = StLatch;
            end

            StLatch: begin
                w_div = 8'd0;
                w_bit = 5'd0;
                if (rom_command == END_CODE) begin
                    w_state = StFinish;
                end else begin
                    // MOSI is the shift register MSB, so bit 23 is on the
                    // wire as soon as cs_n drops.
                    w_shift = rom_command;
                    w_cs_n  = 1'b0;
                    w_state = StShift;
                end
            end

            StShift: begin
                if (r_div == DivLast) begin
                    w_div = 8'd0;
                    if (!r_sclk) begin
                        w_sclk = 1'b1;
                    end else begin
                        // Falling edge: advance data. After 24 shifts the
                        // register is all zeros, which parks MOSI low.
                        w_sclk  = 1'b0;
                        w_shift = {r_shift[22:0], 1'b0};
                        if (r_bit == 5'd23) begin
                            w_cs_n  = 1'b1;
                            w_cnt   = r_cnt + 9'd1;
                            w_gap   = 8'd0;
                            w_state = StGap;
                        end else begin
                            w_bit = r_bit + 5'd1;
                        end
                    end
                end else begin
                    w_div = r_div + 8'd1;
                end
            end

            StGap: begin
                if (r_gap == GapLast) begin
                    w_gap = 8'd0;
                    if (r_addr == 8'hFF) begin
                        w_state = StFinish;
                    end else begin
                        w_addr  = r_addr + 8'd1;
                        w_state = StFetch;
                    end
                end else begin
                    w_gap = r_gap + 8'd1;
                end
            end

            StFinish: begin
                w_busy  = 1'b0;
                w_done  = 1'b1;
                w_state = StIdle;
            end

            default: begin
                w_state = StIdle;
            end
        endcase
    end

    assign rom_address = r_addr;
    assign spi_cs_n    = r_cs_n;
    assign spi_sclk    = r_sclk;
    assign spi_mosi    = r_shift[23];
    assign busy        = r_busy;
    assign done        = r_done;
    assign cmd_count   = r_cnt;

endmodule

// File: tb/tb_afe_config_sequencer.sv
// ----------------------------------------------------------------------------
// tb_afe_config_sequencer
//
// Directed bench. Two instances: dut0 (CLK_DIV=4) and dut1 (CLK_DIV=1), both
// GAP_CYCLES=8, each with its own registered ROM model. A cycle-based SPI
// slave monitor watches the selected instance and records frames, chip-select
// low/high durations, addresses and protocol violations.
// ----------------------------------------------------------------------------
module tb_afe_config_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        start;

    logic [7:0]  addr0, addr1;
    logic [23:0] cmd0, cmd1;
    logic        cs0, cs1, sclk0, sclk1, mosi0, mosi1;
    logic        busy0, busy1, done0, done1;
    logic [8:0]  cnt0, cnt1;

    logic [23:0] rom0 [256];
    logic [23:0] rom1 [256];

    always @(posedge clk) cmd0 <= rom0[addr0];
    always @(posedge clk) cmd1 <= rom1[addr1];

    afe_config_sequencer #(
        .CLK_DIV    (4),
        .GAP_CYCLES (8),
        .END_CODE   (24'hFFFFFF)
    ) dut0 (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .rom_address (addr0),
        .rom_command (cmd0),
        .spi_cs_n    (cs0),
        .spi_sclk    (sclk0),
        .spi_mosi    (mosi0),
        .busy        (busy0),
        .done        (done0),
        .cmd_count   (cnt0)
    );

    afe_config_sequencer #(
        .CLK_DIV    (1),
        .GAP_CYCLES (8),
        .END_CODE   (24'hFFFFFF)
    ) dut1 (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .rom_address (addr1),
        .rom_command (cmd1),
        .spi_cs_n    (cs1),
        .spi_sclk    (sclk1),
        .spi_mosi    (mosi1),
        .busy        (busy1),
        .done        (done1),
        .cmd_count   (cnt1)
    );

    // Monitor / check view of the selected instance
    logic       sel;
    logic       m_cs, m_sclk, m_mosi, m_busy, m_done;
    logic [7:0] m_addr;
    logic [8:0] m_cnt;
    assign m_cs   = sel ? cs1   : cs0;
    assign m_sclk = sel ? sclk1 : sclk0;
    assign m_mosi = sel ? mosi1 : mosi0;
    assign m_busy = sel ? busy1 : busy0;
    assign m_done = sel ? done1 : done0;
    assign m_addr = sel ? addr1 : addr0;
    assign m_cnt  = sel ? cnt1  : cnt0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- SPI slave monitor ----------------
    logic [23:0] q_word [$];
    int          q_rises[$];
    int          q_low  [$];
    int          q_gap  [$];
    int          q_addr [$];
    logic [23:0] m_word;
    int          m_rises, m_low, m_high;
    int          m_glitch, m_mosi_viol, m_notoggle;
    logic        m_seen;
    logic        m_prev_cs = 1'b1, m_prev_sclk = 1'b0, m_prev_mosi = 1'b0;

    task automatic clear_mon();
        q_word.delete();
        q_rises.delete();
        q_low.delete();
        q_gap.delete();
        q_addr.delete();
        m_word      = 24'd0;
        m_rises     = 0;
        m_low       = 0;
        m_high      = 0;
        m_glitch    = 0;
        m_mosi_viol = 0;
        m_notoggle  = 0;
        m_seen      = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (!m_cs) begin
                if (m_prev_cs) begin
                    if (m_seen) q_gap.push_back(m_high);
                    q_addr.push_back(int'(m_addr));
                    m_word  = 24'd0;
                    m_rises = 0;
                    m_low   = 0;
                end
                m_low++;
                if (m_sclk && !m_prev_sclk) begin
                    m_word = {m_word[22:0], m_mosi};
                    m_rises++;
                end
                if (m_sclk && m_prev_sclk && (m_mosi != m_prev_mosi)) m_mosi_viol++;
                if (!m_prev_cs && (m_sclk == m_prev_sclk)) m_notoggle++;
            end else begin
                if (!m_prev_cs) begin
                    q_word.push_back(m_word);
                    q_rises.push_back(m_rises);
                    q_low.push_back(m_low);
                    m_seen = 1'b1;
                    m_high = 0;
                end
                m_high++;
                if (m_sclk) m_glitch++;
            end
            m_prev_cs   = m_cs;
            m_prev_sclk = m_sclk;
            m_prev_mosi = m_mosi;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cycles);
        cycles = 0;
        while (!m_done && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
        if (!m_done) check_eq("done_timeout", {31'd0, m_done}, 32'd1);
    endtask

    function automatic logic [31:0] qw(input int idx);
        return (idx < q_word.size()) ? {8'd0, q_word[idx]} : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] qi(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : 32'hDEAD_BEEF;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_cs_n"},  {31'd0, m_cs},   32'd1);
        check_eq({tag, "_sclk"},  {31'd0, m_sclk}, 32'd0);
        check_eq({tag, "_mosi"},  {31'd0, m_mosi}, 32'd0);
        check_eq({tag, "_busy"},  {31'd0, m_busy}, 32'd0);
        check_eq({tag, "_done"},  {31'd0, m_done}, 32'd0);
        check_eq({tag, "_count"}, {23'd0, m_cnt},  32'd0);
        check_eq({tag, "_addr"},  {24'd0, m_addr}, 32'd0);
    endtask

    int n;

    initial begin
        sel     = 1'b0;
        reset_n = 1'b0;
        start   = 1'b0;
        for (int i = 0; i < 256; i++) begin
            rom0[i] = 24'hFFFFFF;
            rom1[i] = 24'hFFFFFF;
        end
        clear_mon();

        // Reset state, with start held high to show it is ignored in reset
        @(negedge clk);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        check_idle_outputs("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("no_pass_after_reset_busy", {31'd0, m_busy}, 32'd0);

        // Single command then END_CODE
        rom0[0] = 24'h123456;
        rom0[1] = 24'hFFFFFF;
        clear_mon();
        pulse_start();
        check_eq("busy_after_start", {31'd0, m_busy}, 32'd1);
        wait_done(1000, n);
        check_eq("t1_frames", q_word.size(), 32'd1);
        check_eq("t1_word",   qw(0), 32'h123456);
        check_eq("t1_rises",  qi(q_rises, 0), 32'd24);
        check_eq("t1_cs_low", qi(q_low, 0), 32'd192);
        check_eq("t1_count",  {23'd0, m_cnt}, 32'd1);
        check_eq("t1_busy",   {31'd0, m_busy}, 32'd0);
        check_eq("t1_glitch", m_glitch, 32'd0);
        check_eq("t1_mosi_stable", m_mosi_viol, 32'd0);

        // Three commands then END_CODE
        rom0[0] = 24'hA5A5A5;
        rom0[1] = 24'h0F0F0F;
        rom0[2] = 24'hC3C3C3;
        rom0[3] = 24'hFFFFFF;
        clear_mon();
        pulse_start();
        wait_done(3000, n);
        check_eq("t2_frames", q_word.size(), 32'd3);
        check_eq("t2_word0",  qw(0), 32'hA5A5A5);
        check_eq("t2_word1",  qw(1), 32'h0F0F0F);
        check_eq("t2_word2",  qw(2), 32'hC3C3C3);
        check_eq("t2_gap0",   qi(q_gap, 0), 32'd8);
        check_eq("t2_gap1",   qi(q_gap, 1), 32'd8);
        check_eq("t2_addr0",  qi(q_addr, 0), 32'd0);
        check_eq("t2_addr1",  qi(q_addr, 1), 32'd1);
        check_eq("t2_addr2",  qi(q_addr, 2), 32'd2);
        check_eq("t2_addr_end", {24'd0, m_addr}, 32'd3);
        check_eq("t2_count",  {23'd0, m_cnt}, 32'd3);
        check_eq("t2_glitch", m_glitch, 32'd0);

        // END_CODE at word 0: no chip-select activity
        rom0[0] = 24'hFFFFFF;
        clear_mon();
        pulse_start();
        wait_done(50, n);
        check_eq("t3_latency_le4", {31'd0, (n <= 4)}, 32'd1);
        check_eq("t3_cs_falls", q_addr.size(), 32'd0);
        check_eq("t3_count", {23'd0, m_cnt}, 32'd0);
        check_eq("t3_done",  {31'd0, m_done}, 32'd1);

        // Reset in the middle of a frame
        rom0[0] = 24'h5A5A5A;
        rom0[1] = 24'hFFFFFF;
        clear_mon();
        pulse_start();
        n = 0;
        while (m_rises < 10 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_eq("t4_reached_bit10", {31'd0, (m_rises >= 10)}, 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check_idle_outputs("t4_abort");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        check_eq("t4_partial_frame",
                 {31'd0, (qi(q_rises, 0) >= 10 && qi(q_rises, 0) <= 11)}, 32'd1);
        check_eq("t4_no_edges_after", m_glitch, 32'd0);
        rom0[0] = 24'h654321;
        clear_mon();
        pulse_start();
        wait_done(1000, n);
        check_eq("t4_frames", q_word.size(), 32'd1);
        check_eq("t4_addr0",  qi(q_addr, 0), 32'd0);
        check_eq("t4_word",   qw(0), 32'h654321);
        check_eq("t4_count",  {23'd0, m_cnt}, 32'd1);

        // CLK_DIV=1 instance, extra start while busy
        sel     = 1'b1;
        rom1[0] = 24'hABCDEF;
        rom1[1] = 24'h13579B;
        rom1[2] = 24'hFFFFFF;
        repeat (2) @(negedge clk);
        clear_mon();
        pulse_start();
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1000, n);
        repeat (50) @(negedge clk);
        check_eq("t5_frames",   q_word.size(), 32'd2);
        check_eq("t5_word0",    qw(0), 32'hABCDEF);
        check_eq("t5_word1",    qw(1), 32'h13579B);
        check_eq("t5_cs_low",   qi(q_low, 0), 32'd48);
        check_eq("t5_toggle",   m_notoggle, 32'd0);
        check_eq("t5_count",    {23'd0, m_cnt}, 32'd2);
        check_eq("t5_idle",     {31'd0, m_busy}, 32'd0);
        check_eq("t5_mosi_stable", m_mosi_viol, 32'd0);

        // No END_CODE anywhere: 256 frames, stop at address 255
        for (int i = 0; i < 256; i++) begin
            rom1[i] = {8'(i), ~8'(i), 8'(i)};
        end
        clear_mon();
        pulse_start();
        wait_done(20000, n);
        check_eq("t6_frames",   q_word.size(), 32'd256);
        check_eq("t6_count",    {23'd0, m_cnt}, 32'd256);
        check_eq("t6_addr_end", {24'd0, m_addr}, 32'd255);
        check_eq("t6_addr_last", qi(q_addr, 255), 32'd255);
        check_eq("t6_word_last", qw(255), 32'hFF00FF);
        check_eq("t6_word_7",    qw(7), 32'h07F807);
        repeat (20) @(negedge clk);
        check_eq("t6_no_wrap",  q_word.size(), 32'd256);
        check_eq("t6_glitch",   m_glitch, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
